// File: rtl/dlf_kcounter_adaptive_if.sv
// Control/status bundle for the adaptive K-counter loop filter.
// The master side drives the step and mode inputs; the slave side returns pulses and K status.
interface dlf_kcounter_adaptive_if #(
  parameter int MODE_W = 5
);
  logic              enable;
  logic              dirSig;
  logic [MODE_W-1:0] kMode;
  logic              autoK;
  logic              carry;
  logic              borrow;
  logic              lock;
  logic [MODE_W-1:0] kCur;

  modport master (
    output enable, dirSig, kMode, autoK,
    input  carry, borrow, lock, kCur
  );

  modport slave (
    input  enable, dirSig, kMode, autoK,
    output carry, borrow, lock, kCur
  );
endinterface

// File: rtl/dlf_kcounter_adaptive.sv
// DPLL loop filter: K up/down counter that emits one-cycle carry/borrow pulses on wrap.
// In auto mode K widens after LOCK_WIN quiet cycles and narrows on fast wraps.
module dlf_kcounter_adaptive #(
  parameter int CNT_W    = 20,
  parameter int MODE_W   = 5,
  parameter int K_MIN    = 3,
  parameter int K_MAX    = 17,
  parameter int LOCK_WIN = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  dlf_kcounter_adaptive_if.slave  bus
);

  localparam int Q_W = $clog2(LOCK_WIN + 1);
  localparam logic [MODE_W-1:0] KMIN_V = MODE_W'(K_MIN);
  localparam logic [MODE_W-1:0] KMAX_V = MODE_W'(K_MAX);
  localparam logic [Q_W-1:0]    Q_FULL = Q_W'(LOCK_WIN);
  localparam logic [Q_W-1:0]    Q_FAST = Q_W'(LOCK_WIN / 4);

  typedef enum logic [1:0] {MANUAL, ACQ, LOCKED} state_e;

  function automatic logic [MODE_W-1:0] clamp_k(input logic [MODE_W-1:0] k);
    if (k < KMIN_V)      return KMIN_V;
    else if (k > KMAX_V) return KMAX_V;
    else                 return k;
  endfunction

  function automatic logic [CNT_W-1:0] mid_of(input logic [MODE_W-1:0] k);
    return CNT_W'(1) << (k - MODE_W'(1));
  endfunction

  function automatic logic [CNT_W-1:0] top_of(input logic [MODE_W-1:0] k);
    return (CNT_W'(1) << k) - CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [MODE_W-1:0] k_q, k_d, k_req;
  logic [CNT_W-1:0]  cnt_q, cnt_d, stepped;
  logic [Q_W-1:0]    quiet_q, quiet_d, quiet_inc;
  logic              carry_q, carry_d, borrow_q, borrow_d, lock_q, lock_d;
  logic              wrap_up, wrap_dn, wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= bus.autoK ? ACQ : MANUAL;
      k_q      <= k_req;
      cnt_q    <= mid_of(k_req);
      quiet_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      quiet_q  <= quiet_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    quiet_d   = quiet_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    k_req     = clamp_k(bus.kMode);
    wrap_up   = bus.dirSig && (cnt_q == top_of(k_q));
    wrap_dn   = !bus.dirSig && (cnt_q == '0);
    wrap      = wrap_up || wrap_dn;
    stepped   = wrap ? mid_of(k_q) : (bus.dirSig ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1));
    quiet_inc = (quiet_q == Q_FULL) ? quiet_q : quiet_q + Q_W'(1);

    if (!bus.autoK) begin
      state_d = MANUAL;
      quiet_d = '0;
      if (k_req != k_q) begin
        k_d   = k_req;
        cnt_d = mid_of(k_req);
      end else if (bus.enable) begin
        cnt_d    = stepped;
        carry_d  = wrap_up;
        borrow_d = wrap_dn;
      end
    end else if (state_q == MANUAL) begin
      state_d = ACQ;
      quiet_d = '0;
      if (bus.enable) begin
        cnt_d    = stepped;
        carry_d  = wrap_up;
        borrow_d = wrap_dn;
      end
    end else if (bus.enable) begin
      if (!wrap) begin
        cnt_d   = stepped;
        quiet_d = quiet_inc;
        if (quiet_inc == Q_FULL) begin
          state_d = LOCKED;
          if (k_q < KMAX_V) begin
            k_d     = k_q + MODE_W'(1);
            cnt_d   = mid_of(k_q + MODE_W'(1));
            quiet_d = '0;
          end
        end
      end else begin
        quiet_d = '0;
        // A fast wrap that narrows K swallows its own pulse; at K_MIN it passes through.
        if (quiet_q < Q_FAST && k_q > KMIN_V) begin
          state_d = ACQ;
          k_d     = k_q - MODE_W'(1);
          cnt_d   = mid_of(k_q - MODE_W'(1));
        end else begin
          if (quiet_q < Q_FAST) state_d = ACQ;
          cnt_d    = stepped;
          carry_d  = wrap_up;
          borrow_d = wrap_dn;
        end
      end
    end
  end

  always_comb begin
    lock_d = (state_d == LOCKED);
  end

  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.lock   = lock_q;
  assign bus.kCur   = k_q;

endmodule

// File: tb/tb_dlf_kcounter_adaptive.sv
// Bench for the adaptive K-counter loop filter: directed scenarios plus random traffic,
// all checked against a behavioural model of the counting and K-adaptation rules.
module tb_dlf_kcounter_adaptive;

  localparam int K_MIN = 3;
  localparam int K_MAX = 17;
  localparam int LWIN  = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dlf_kcounter_adaptive_if #(.MODE_W(5)) ifc ();

  dlf_kcounter_adaptive #(
    .CNT_W(20), .MODE_W(5), .K_MIN(K_MIN), .K_MAX(K_MAX), .LOCK_WIN(LWIN)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  always #5 clk = ~clk;

  // Model state: counter value, K, quiet run length, auto-mode active, locked.
  int m_cnt, m_k, m_quiet;
  bit m_auto, m_locked, m_carry, m_borrow;

  function automatic int clampk(input int k);
    if (k < K_MIN) return K_MIN;
    if (k > K_MAX) return K_MAX;
    return k;
  endfunction

  task automatic model_plain(input bit up, input bit wrap);
    if (wrap) begin
      m_cnt    = 1 << (m_k - 1);
      m_carry  = up;
      m_borrow = !up;
    end else begin
      m_cnt = up ? m_cnt + 1 : m_cnt - 1;
    end
  endtask

  task automatic model_step();
    bit up, wrap;
    int nk;
    m_carry  = 0;
    m_borrow = 0;
    if (reset) begin
      m_k = clampk(int'(ifc.kMode)); m_cnt = 1 << (m_k - 1); m_quiet = 0;
      m_auto = ifc.autoK; m_locked = 0;
      return;
    end
    up   = ifc.dirSig;
    wrap = up ? (m_cnt == (1 << m_k) - 1) : (m_cnt == 0);
    if (!ifc.autoK) begin
      m_auto = 0; m_locked = 0; m_quiet = 0;
      nk = clampk(int'(ifc.kMode));
      if (nk != m_k) begin
        m_k = nk; m_cnt = 1 << (nk - 1);
      end else if (ifc.enable) model_plain(up, wrap);
    end else if (!m_auto) begin
      m_auto = 1; m_quiet = 0;
      if (ifc.enable) model_plain(up, wrap);
    end else if (ifc.enable) begin
      if (!wrap) begin
        m_cnt   = up ? m_cnt + 1 : m_cnt - 1;
        m_quiet = (m_quiet + 1 > LWIN) ? LWIN : m_quiet + 1;
        if (m_quiet == LWIN) begin
          m_locked = 1;
          if (m_k < K_MAX) begin m_k++; m_cnt = 1 << (m_k - 1); m_quiet = 0; end
        end
      end else if (m_quiet < LWIN / 4) begin
        m_quiet = 0; m_locked = 0;
        if (m_k > K_MIN) begin m_k--; m_cnt = 1 << (m_k - 1); end
        else model_plain(up, wrap);
      end else begin
        m_quiet = 0;
        model_plain(up, wrap);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input int kmode, input bit autok);
    reset = 1'b1; ifc.enable = 1'b0; ifc.dirSig = 1'b0;
    ifc.kMode = 5'(kmode); ifc.autoK = autok;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3, 0);
    checks++;
    if ({ifc.carry, ifc.borrow, ifc.lock, ifc.kCur} !== {1'b0, 1'b0, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL reset: got c=%b b=%b l=%b k=%0d, want c=0 b=0 l=0 k=3",
               ifc.carry, ifc.borrow, ifc.lock, ifc.kCur);
    end
  endtask

  task automatic test_manual_carry();
    do_reset(3, 0);
    ifc.enable = 1; ifc.dirSig = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.carry !== (i == 3) || ifc.borrow !== 1'b0 || ifc.carry !== m_carry) begin
        errors++;
        $display("FAIL manual_carry up%0d: got c=%b b=%b, want c=%b b=0", i + 1, ifc.carry, ifc.borrow, (i == 3));
      end
    end
  endtask

  task automatic test_manual_borrow();
    do_reset(3, 0);
    ifc.enable = 1; ifc.dirSig = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ifc.borrow !== (i == 4) || ifc.carry !== 1'b0 || ifc.borrow !== m_borrow) begin
        errors++;
        $display("FAIL manual_borrow down%0d: got b=%b c=%b, want b=%b c=0", i + 1, ifc.borrow, ifc.carry, (i == 4));
      end
    end
  endtask

  task automatic test_clamp();
    int kseq[4] = '{0, 31, 3, 5};
    int kexp[4] = '{3, 17, 3, 5};
    do_reset(3, 0);
    for (int i = 0; i < 4; i++) begin
      ifc.kMode = 5'(kseq[i]);
      ifc.enable = (i == 3); ifc.dirSig = 1;
      tick();
      checks++;
      if (ifc.kCur !== 5'(kexp[i]) || ifc.carry !== 1'b0 || ifc.kCur !== 5'(m_k)) begin
        errors++;
        $display("FAIL clamp kMode=%0d: got k=%0d c=%b, want k=%0d c=0", kseq[i], ifc.kCur, ifc.carry, kexp[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (ifc.carry !== (i == 15) || ifc.carry !== m_carry) begin
        errors++;
        $display("FAIL clamp_reload up%0d: got c=%b, want c=%b", i + 1, ifc.carry, (i == 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(3, 0);
    ifc.enable = 1; ifc.dirSig = 1;
    for (int i = 0; i < 26; i++) begin
      if (i == 16) ifc.dirSig = 0;
      tick();
      checks++;
      if (ifc.carry !== m_carry || ifc.borrow !== m_borrow || (ifc.carry && ifc.borrow)) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got c=%b b=%b, want c=%b b=%b", i, ifc.carry, ifc.borrow, m_carry, m_borrow);
      end
    end
  endtask

  task automatic test_auto_widen();
    do_reset(3, 1);
    ifc.enable = 1;
    for (int k = 4; k <= K_MAX + 1; k++) begin
      for (int i = 0; i < LWIN; i++) begin
        ifc.dirSig = (i % 2 == 0);
        tick();
      end
      checks++;
      if (ifc.kCur !== 5'((k > K_MAX) ? K_MAX : k) || ifc.lock !== 1'b1 || ifc.kCur !== 5'(m_k)) begin
        errors++;
        $display("FAIL auto_widen step%0d: got k=%0d l=%b, want k=%0d l=1", k, ifc.kCur, ifc.lock, (k > K_MAX) ? K_MAX : k);
      end
    end
  endtask

  task automatic test_fast_narrow();
    int run[3]  = '{16, 8, 4};
    int kexp[3] = '{4, 3, 3};
    do_reset(5, 1);
    ifc.enable = 1; ifc.dirSig = 1;
    for (int s = 0; s < 3; s++) begin
      repeat (run[s]) tick();
      checks++;
      if (ifc.kCur !== 5'(kexp[s]) || ifc.lock !== 1'b0 || ifc.carry !== (s == 2) || ifc.carry !== m_carry) begin
        errors++;
        $display("FAIL fast_narrow seg%0d: got k=%0d l=%b c=%b, want k=%0d l=0 c=%b",
                 s, ifc.kCur, ifc.lock, ifc.carry, kexp[s], (s == 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(3, 0);
    ifc.enable = 1; ifc.dirSig = 1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ifc.carry, ifc.borrow, ifc.lock, ifc.kCur} !== {1'b0, 1'b0, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL reset_mid: got c=%b b=%b l=%b k=%0d, want c=0 b=0 l=0 k=3",
               ifc.carry, ifc.borrow, ifc.lock, ifc.kCur);
    end
    tick();
    checks++;
    if (ifc.carry !== 1'b0 || ifc.carry !== m_carry) begin
      errors++;
      $display("FAIL reset_mid_after: got c=%b, want c=0", ifc.carry);
    end
  endtask

  task automatic test_random();
    do_reset(4, 1);
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(499) == 0);
      ifc.enable   = ($urandom_range(99) < 85);
      ifc.dirSig   = ($urandom_range(99) < (((i / 300) % 2) ? 70 : 50));
      if ($urandom_range(199) == 0) ifc.autoK = ~ifc.autoK;
      if ($urandom_range(99) == 0)
        ifc.kMode = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(8, 3));
      tick();
      checks++;
      if ({ifc.carry, ifc.borrow, ifc.lock, ifc.kCur} !== {m_carry, m_borrow, m_locked, 5'(m_k)}) begin
        errors++;
        $display("FAIL random cyc%0d: got c=%b b=%b l=%b k=%0d, want c=%b b=%b l=%b k=%0d",
                 i, ifc.carry, ifc.borrow, ifc.lock, ifc.kCur, m_carry, m_borrow, m_locked, m_k);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ifc.enable = 0; ifc.dirSig = 0; ifc.kMode = 5'd3; ifc.autoK = 0;
    test_reset();
    test_manual_carry();
    test_manual_borrow();
    test_clamp();
    test_back_to_back();
    test_auto_widen();
    test_fast_narrow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
